// File: rtl/rom_read_arbiter_if.sv
// Bundle of request, response and ROM-port signals for rom_read_arbiter.
// The slave modport is the arbiter; the master modport is the requester/ROM side.
interface rom_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
);
   // Handshake: requester i presents req_valid[i] with req_addr[i] and must hold both
   // until req_ready[i]; the read is accepted in the cycle where both are 1.
   // Dropping req_valid before ready withdraws the request. Responses (rsp_valid
   // one-hot pulse with rsp_data) have no backpressure and must be taken when shown.
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic [ADDR_W-1:0]         rom_addr;
   logic                      rom_en;
   logic [DATA_W-1:0]         rom_data;
   logic [2:0]                dbg_ptr;

   modport slave (
      input  req_valid, req_addr, rom_data,
      output req_ready, rsp_valid, rsp_data, rom_addr, rom_en, dbg_ptr
   );

   modport master (
      output req_valid, req_addr, rom_data,
      input  req_ready, rsp_valid, rsp_data, rom_addr, rom_en, dbg_ptr
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter for the single read port of a 256x8 lookup ROM, with latency tracking.
// Build option ROM_OUTREG_EN: ROM output register enabled, read latency 2 instead of 1.
module rom_read_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   rom_read_arbiter_if.slave  bus
);

`ifdef ROM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic [2:0]         ptr_q, ptr_d;
   logic               grant_found;
   logic [2:0]         grant_idx;
   logic [NUM_REQ-1:0] grant_oh;
   int                 scan_pos;
   logic [ADDR_W-1:0]  rom_addr_c;

   logic [LAT-1:0]     pipe_vld_q, pipe_vld_d;
   logic [2:0]         pipe_id_q [LAT];
   logic [2:0]         pipe_id_d [LAT];

   logic               rsp_fire;
   logic [NUM_REQ-1:0] rsp_valid_c;
   logic [DATA_W-1:0]  rsp_data_c;

   // Scan from ptr, wrapping; nothing is granted while reset flushes the pipe.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = 3'd0;
      scan_pos    = 0;
      if (!reset) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = int'(ptr_q) + k;
            if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!grant_found && scan_pos == i && bus.req_valid[i]) begin
                  grant_found = 1'b1;
                  grant_idx   = 3'(i);
               end
            end
         end
      end
   end

   always_comb begin
      grant_oh   = '0;
      rom_addr_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_found && grant_idx == 3'(i)) begin
            grant_oh[i] = 1'b1;
            rom_addr_c  = bus.req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_found) begin
         if (grant_idx == 3'(NUM_REQ - 1)) ptr_d = 3'd0;
         else                              ptr_d = grant_idx + 3'd1;
      end
   end

   always_comb begin
      pipe_vld_d    = '0;
      pipe_vld_d[0] = grant_found;
      for (int s = 0; s < LAT; s++) pipe_id_d[s] = 3'd0;
      pipe_id_d[0]  = grant_idx;
      for (int s = 1; s < LAT; s++) begin
         pipe_vld_d[s] = pipe_vld_q[s-1];
         pipe_id_d[s]  = pipe_id_q[s-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q      <= 3'd0;
         pipe_vld_q <= '0;
         for (int s = 0; s < LAT; s++) pipe_id_q[s] <= 3'd0;
      end else begin
         ptr_q      <= ptr_d;
         pipe_vld_q <= pipe_vld_d;
         for (int s = 0; s < LAT; s++) pipe_id_q[s] <= pipe_id_d[s];
      end
   end

   // A read still in the pipe when reset is sampled must not surface that cycle.
   assign rsp_fire = pipe_vld_q[LAT-1] & ~reset;

   always_comb begin
      rsp_valid_c = '0;
      rsp_data_c  = '0;
      if (rsp_fire) rsp_data_c = bus.rom_data;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rsp_fire && pipe_id_q[LAT-1] == 3'(i)) rsp_valid_c[i] = 1'b1;
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.rom_en    = grant_found;
   assign bus.rom_addr  = rom_addr_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_data  = rsp_data_c;
   assign bus.dbg_ptr   = ptr_q;

endmodule
